// File: rtl/fetch_queue.sv
// fetch_queue: in-order {PC, instruction} buffer between fetch and decode with flush.
// Optional same-cycle empty-queue bypass is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned INST_W = 9,
   parameter int unsigned ADDR_W = 10
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic                     Flush,
   input  logic                     InValid,
   input  logic [INST_W-1:0]        InInst,
   input  logic [ADDR_W-1:0]        InPC,
   output logic                     InReady,
   output logic                     OutValid,
   output logic [INST_W-1:0]        OutInst,
   output logic [ADDR_W-1:0]        OutPC,
   input  logic                     OutReady,
   output logic [$clog2(DEPTH):0]   Count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

   logic [INST_W-1:0] inst_q [DEPTH];
   logic [INST_W-1:0] inst_d [DEPTH];
   logic [ADDR_W-1:0] pc_q   [DEPTH];
   logic [ADDR_W-1:0] pc_d   [DEPTH];

   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic empty, full;
   logic byp_valid, byp_consume;
   logic push, pop, do_write, do_read;
   logic [INST_W-1:0] head_inst;
   logic [ADDR_W-1:0] head_pc;

   always_comb begin
      empty = (count_q == '0);
      full  = (count_q == FullCnt);
`ifdef FETCH_QUEUE_BYPASS_EN
      byp_valid = !Reset && empty && InValid && !Flush;
`else
      byp_valid = 1'b0;
`endif
      InReady  = !Reset && !full;
      OutValid = !empty || byp_valid;
      if (byp_valid) begin
         head_inst = InInst;
         head_pc   = InPC;
      end else begin
         head_inst = inst_q[rptr_q];
         head_pc   = pc_q[rptr_q];
      end
      OutInst = OutValid ? head_inst : '0;
      OutPC   = OutValid ? head_pc   : '0;
      Count   = count_q;
   end

   always_comb begin
      push        = InValid && InReady && !Flush;
      pop         = OutValid && OutReady && !Flush;
      // A bypassed entry that decode takes right away never touches storage.
      byp_consume = byp_valid && OutReady;
      do_write    = push && !byp_consume;
      do_read     = pop && !byp_consume;

      inst_d  = inst_q;
      pc_d    = pc_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;

      if (do_write) begin
         inst_d[wptr_q] = InInst;
         pc_d[wptr_q]   = InPC;
         wptr_d         = wptr_q + PTR_W'(1);
      end
      if (do_read) begin
         rptr_d = rptr_q + PTR_W'(1);
      end
      unique case ({do_write, do_read})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (Flush) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage is deliberately left out of reset; only the pointers define validity.
   always_ff @(posedge Clk) begin
      inst_q <= inst_d;
      pc_q   <= pc_d;
   end

endmodule
